// File: rtl/act_sparse_packer_pkg.sv
// Shared types and default geometry for the sparse activation packer.
// Optional statistics counters are enabled with ACT_SPARSE_PACKER_STATS_EN.
package act_pack_pkg;

  localparam int P_W     = 8;
  localparam int P_GROUP = 8;
  localparam int P_OW    = 32;

  localparam int BYTES_PER_BEAT = P_OW / P_W;
  localparam int CNT_W          = $clog2(P_GROUP + 1);
  localparam int IDX_W          = $clog2(P_GROUP);

  // Mask beat layout: bitmap in the low GROUP bits, kept count directly above.
  localparam int MASK_LSB = 0;
  localparam int CNT_LSB  = P_GROUP;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    MASK = 2'd1,
    DATA = 2'd2
  } pack_state_e;

endpackage

// File: rtl/act_sparse_packer_beat_mux.sv
// Selects the kept bytes belonging to one data beat, zero-filling lanes past
// the kept count.
module act_pack_beat_mux
  import act_pack_pkg::*;
#(
  parameter int W     = P_W,
  parameter int GROUP = P_GROUP,
  parameter int OW    = P_OW,
  parameter int CW    = $clog2(GROUP + 1),
  parameter int IW    = $clog2(GROUP)
) (
  input  logic [W-1:0]  i_buf [GROUP],
  input  logic [CW-1:0] i_ptr,
  input  logic [CW-1:0] i_kcnt,
  output logic [OW-1:0] o_data
);

  localparam int unsigned BPB = OW / W;

  // Lane l of beat p carries buffer entry p*BPB + l when that entry was kept.
  always_comb begin
    o_data = '0;
    for (int unsigned l = 0; l < BPB; l++) begin
      if ((32'(i_ptr) * BPB + l) < 32'(i_kcnt)) begin
        o_data[l*W +: W] = i_buf[IW'(32'(i_ptr) * BPB + l)];
      end else begin
        o_data[l*W +: W] = '0;
      end
    end
  end

endmodule

// File: rtl/act_sparse_packer.sv
// Packs GROUP activations into a mask beat plus densely packed kept bytes.
// Define ACT_SPARSE_PACKER_STATS_EN to add element/kept statistics outputs.
module act_sparse_packer
  import act_pack_pkg::*;
#(
  parameter int W     = P_W,
  parameter int GROUP = P_GROUP,
  parameter int OW    = P_OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_keep,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_is_mask,
  output logic          out_last
`ifdef ACT_SPARSE_PACKER_STATS_EN
  ,
  output logic [31:0]   stat_total,
  output logic [31:0]   stat_kept
`endif
);

  localparam int unsigned BPB = OW / W;
  localparam int CW      = $clog2(GROUP + 1);
  localparam int IW      = $clog2(GROUP);
  localparam int CNT_OFS = GROUP;

  pack_state_e         r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [GROUP-1:0]    r_mask, w_mask_nxt;
  logic [CW-1:0]       r_kcnt, w_kcnt_nxt;
  logic [CW-1:0]       r_ptr, w_ptr_nxt;
  logic                r_last_grp, w_last_nxt;
  logic [W-1:0]        r_buf [GROUP];
  logic [W-1:0]        w_buf_nxt [GROUP];

  logic                r_out_valid, r_out_is_mask, r_out_last, r_in_ready;
  logic [OW-1:0]       r_out_data;
  logic [OW-1:0]       w_beat, w_mask_beat, w_out_data_nxt;
  logic                w_out_last_nxt;
  logic                w_acc, w_out_hs;

  assign w_acc    = in_valid & r_in_ready;
  assign w_out_hs = r_out_valid & out_ready;

  function automatic logic is_final(input logic [CW-1:0] p, input logic [CW-1:0] k);
    return ((32'(p) + 32'd1) * BPB) >= 32'(k);
  endfunction

  act_pack_beat_mux #(
    .W(W), .GROUP(GROUP), .OW(OW), .CW(CW), .IW(IW)
  ) u_beat_mux (
    .i_buf  (w_buf_nxt),
    .i_ptr  (w_ptr_nxt),
    .i_kcnt (w_kcnt_nxt),
    .o_data (w_beat)
  );

  // Next-state and group bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mask_nxt  = r_mask;
    w_kcnt_nxt  = r_kcnt;
    w_ptr_nxt   = r_ptr;
    w_last_nxt  = r_last_grp;
    w_buf_nxt   = r_buf;
    case (r_state)
      FILL: begin
        if (w_acc) begin
          w_mask_nxt[r_idx] = in_keep;
          if (in_keep) begin
            w_buf_nxt[r_kcnt[IW-1:0]] = in_data;
            w_kcnt_nxt = r_kcnt + CW'(1);
          end else begin
            w_kcnt_nxt = r_kcnt;
          end
          w_idx_nxt = r_idx + IW'(1);
          if ((r_idx == IW'(GROUP - 1)) || in_last) begin
            w_last_nxt  = in_last;
            w_state_nxt = MASK;
          end else begin
            w_state_nxt = FILL;
          end
        end else begin
          w_state_nxt = FILL;
        end
      end
      MASK: begin
        if (w_out_hs) begin
          if (r_kcnt == '0) begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
            w_mask_nxt  = '0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = DATA;
            w_ptr_nxt   = '0;
          end
        end else begin
          w_state_nxt = MASK;
        end
      end
      DATA: begin
        if (w_out_hs) begin
          if (is_final(r_ptr, r_kcnt)) begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
            w_mask_nxt  = '0;
            w_kcnt_nxt  = '0;
            w_ptr_nxt   = '0;
            w_last_nxt  = 1'b0;
          end else begin
            w_ptr_nxt = r_ptr + CW'(1);
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      default: begin
        w_state_nxt = FILL;
        w_idx_nxt   = '0;
        w_mask_nxt  = '0;
        w_kcnt_nxt  = '0;
        w_ptr_nxt   = '0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // Output beat contents for the upcoming state; registered below.
  always_comb begin
    w_mask_beat = '0;
    w_mask_beat[GROUP-1:0]     = w_mask_nxt;
    w_mask_beat[CNT_OFS +: CW] = w_kcnt_nxt;
    case (w_state_nxt)
      MASK: begin
        w_out_data_nxt = w_mask_beat;
        w_out_last_nxt = w_last_nxt && (w_kcnt_nxt == '0);
      end
      DATA: begin
        w_out_data_nxt = w_beat;
        w_out_last_nxt = w_last_nxt && is_final(w_ptr_nxt, w_kcnt_nxt);
      end
      default: begin
        w_out_data_nxt = '0;
        w_out_last_nxt = 1'b0;
      end
    endcase
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FILL;
      r_idx         <= '0;
      r_mask        <= '0;
      r_kcnt        <= '0;
      r_ptr         <= '0;
      r_last_grp    <= 1'b0;
      for (int i = 0; i < GROUP; i++) r_buf[i] <= '0;
      r_out_valid   <= 1'b0;
      r_out_is_mask <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_data    <= '0;
      r_in_ready    <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_mask        <= w_mask_nxt;
      r_kcnt        <= w_kcnt_nxt;
      r_ptr         <= w_ptr_nxt;
      r_last_grp    <= w_last_nxt;
      r_buf         <= w_buf_nxt;
      r_out_valid   <= (w_state_nxt != FILL);
      r_out_is_mask <= (w_state_nxt == MASK);
      r_out_last    <= w_out_last_nxt;
      r_out_data    <= w_out_data_nxt;
      r_in_ready    <= (w_state_nxt == FILL);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_is_mask = r_out_is_mask;
  assign out_last    = r_out_last;

`ifdef ACT_SPARSE_PACKER_STATS_EN
  logic [31:0] r_stat_total, r_stat_kept;
  logic        r_new_tensor;

  // Saturating tensor statistics; restart on the first element after out_last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_total <= 32'd0;
      r_stat_kept  <= 32'd0;
      r_new_tensor <= 1'b0;
    end else if (w_acc) begin
      r_new_tensor <= 1'b0;
      if (r_new_tensor) begin
        r_stat_total <= 32'd1;
        r_stat_kept  <= {31'd0, in_keep};
      end else begin
        if (r_stat_total != 32'hFFFF_FFFF) r_stat_total <= r_stat_total + 32'd1;
        if (in_keep && (r_stat_kept != 32'hFFFF_FFFF)) r_stat_kept <= r_stat_kept + 32'd1;
      end
    end else if (w_out_hs && r_out_last) begin
      r_new_tensor <= 1'b1;
    end
  end

  assign stat_total = r_stat_total;
  assign stat_kept  = r_stat_kept;
`endif

endmodule

// File: tb/tb_act_sparse_packer.sv
// Self-checking bench for act_sparse_packer (default build, stats disabled).
module tb_act_sparse_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_keep, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_is_mask, out_last;
  logic [31:0] out_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  grp_d[$];
  bit          grp_k[$];
  logic [31:0] exp_data[$];
  bit          exp_mask[$];
  bit          exp_last[$];

  act_sparse_packer #(.W(8), .GROUP(8), .OW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_mask(out_is_mask), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: mask bitmap + kept count, then kept bytes four per word, LSB first.
  task automatic model(input bit last);
    logic [31:0] m;
    logic [31:0] w;
    logic [7:0]  kept[$];
    m = 32'd0;
    kept.delete();
    foreach (grp_d[i]) if (grp_k[i]) begin
      m[i] = 1'b1;
      kept.push_back(grp_d[i]);
    end
    m = m | (32'(kept.size()) << 8);
    exp_data.push_back(m);
    exp_mask.push_back(1'b1);
    exp_last.push_back(last && (kept.size() == 0));
    for (int b = 0; b < kept.size(); b += 4) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++) if (b + j < kept.size()) w = w | (32'(kept[b+j]) << (8*j));
      exp_data.push_back(w);
      exp_mask.push_back(1'b0);
      exp_last.push_back(last && (b + 4 >= kept.size()));
    end
  endtask

  task automatic send_group(input bit last, input int idle_max);
    int n;
    n = grp_d.size();
    model(last);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, idle_max)) begin
        in_valid = 1'b0;
        tick();
        check("idle_out_valid", 64'(out_valid), 64'd0);
      end
      check("fill_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data  = grp_d[i];
      in_keep  = grp_k[i];
      in_last  = last && (i == n - 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check(i == n - 1 ? "mask_latency" : "fill_no_out", 64'(out_valid), 64'(i == n - 1));
    end
  endtask

  task automatic collect(input int stall);
    logic [31:0] ed;
    bit em, el;
    int s;
    while (exp_data.size() > 0) begin
      ed = exp_data.pop_front();
      em = exp_mask.pop_front();
      el = exp_last.pop_front();
      s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int c = 0; c < s; c++) begin
        out_ready = 1'b0;
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(ed));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        tick();
      end
      out_ready = 1'b1;
      check("beat_valid", 64'(out_valid), 64'd1);
      check("beat_data", 64'(out_data), 64'(ed));
      check("beat_is_mask", 64'(out_is_mask), 64'(em));
      check("beat_last", 64'(out_last), 64'(el));
      tick();
      out_ready = 1'b0;
    end
    check("post_out_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic set_group(input int n, input logic [7:0] base, input logic [15:0] keep);
    grp_d.delete();
    grp_k.delete();
    for (int i = 0; i < n; i++) begin
      grp_d.push_back(base + 8'(i));
      grp_k.push_back(keep[i]);
    end
  endtask

  initial begin
    int n;
    bit lst;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_keep = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_is_mask", 64'(out_is_mask), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Full dense group, not last.
    set_group(8, 8'h01, 16'h00FF);
    send_group(1'b0, 0);
    collect(0);

    // Mixed keep, closed by last on idx7.
    set_group(8, 8'h11, 16'h00A5);
    send_group(1'b1, 0);
    collect(0);

    // All pruned, last on idx7: single mask beat.
    set_group(8, 8'h40, 16'h0000);
    send_group(1'b1, 0);
    collect(0);

    // Short group closed by last on the third element.
    grp_d = '{8'hAA, 8'hBB, 8'hCC};
    grp_k = '{1'b1, 1'b0, 1'b1};
    send_group(1'b1, 0);
    collect(0);

    // Long back-pressure on every beat.
    set_group(8, 8'h60, 16'h00F7);
    send_group(1'b0, 1);
    collect(5);

    // Reset asserted while a data beat is pending.
    set_group(8, 8'h80, 16'h00FF);
    send_group(1'b0, 0);
    out_ready = 1'b1;
    check("mr_mask_data", 64'(out_data), 64'(exp_data[0]));
    tick();
    out_ready = 1'b0;
    check("mr_in_data", 64'(out_is_mask), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_out_data", 64'(out_data), 64'd0);
    check("mr_out_last", 64'(out_last), 64'd0);
    exp_data.delete(); exp_mask.delete(); exp_last.delete();
    tick();
    rst = 1'b0;
    tick();
    set_group(5, 8'hC0, 16'h0016);
    send_group(1'b1, 0);
    collect(0);

    // Randomized groups.
    for (int g = 0; g < 30; g++) begin
      n = int'($urandom_range(1, 8));
      lst = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      grp_d.delete();
      grp_k.delete();
      for (int i = 0; i < n; i++) begin
        grp_d.push_back(8'($urandom));
        grp_k.push_back(1'($urandom_range(0, 1)));
      end
      send_group(lst, 2);
      collect(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
